// File: rtl/neosd_cmd_fsm.sv
// NEOSD command-line engine: serialises one 48-bit command frame with CRC7 on the
// SD CMD line and collects the card response. It checks the response for timeout
// and CRC errors. All progress is gated by the clock generator's bit strobe.
module neosd_cmd_fsm #(
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC_GAP = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [5:0]   cmd_idx_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   rsp_type_i,
    output logic [135:0] rsp_o,
    output logic         done_o,
    output logic         err_timeout_o,
    output logic         err_crc_o,
    output logic         busy_o,
    input  logic         clkstrb_i,
    input  logic         sd_clk_en_i,
    output logic         sd_clk_req_o,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe_o,
    input  logic         sd_cmd_i
);

    typedef enum logic [2:0] {
        StIdle,
        StTx,
        StWaitStart,
        StRx,
        StGap,
        StDone
    } state_e;

    localparam logic [15:0] NcrMax = 16'(NCR_MAX);
    localparam logic [15:0] NccGap = 16'(NCC_GAP);

    // One CRC7 step, polynomial x^7 + x^3 + 1, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // CRC7 over the 40 leading frame bits, computed in one cycle at accept.
    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    state_e         r_state;
    logic [47:0]    r_frame;
    logic [7:0]     r_bit_cnt;
    logic [15:0]    r_tmo_cnt;
    logic [15:0]    r_gap_cnt;
    logic [1:0]     r_rsp_type;
    logic [135:0]   r_rsp;
    logic [6:0]     r_crc;
    logic           r_crc_bad;
    logic           r_done;
    logic           r_err_tmo;
    logic           r_err_crc;
    logic           r_clk_req;
    logic           r_cmd;
    logic           r_cmd_oe;
    logic           r_ready;
    logic           r_busy;

    logic           w_tick;
    logic [6:0]     w_tx_crc;
    logic           w_long;
    logic [7:0]     w_last;
    logic [7:0]     w_data_lo;
    logic [7:0]     w_data_hi;

    assign w_tick    = clkstrb_i & sd_clk_en_i;
    assign w_tx_crc  = crc7_40({2'b01, cmd_idx_i, cmd_arg_i});
    // Receive index windows: CRC covers [47:8] of a short or [127:8] of a long
    // response; the received bit index counts from the start bit (index 0).
    assign w_long    = (r_rsp_type == 2'b10);
    assign w_last    = w_long ? 8'd135 : 8'd47;
    assign w_data_lo = w_long ? 8'd8 : 8'd0;
    assign w_data_hi = w_long ? 8'd127 : 8'd39;

    // Command/response state machine with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state    <= StIdle;
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_rsp_type <= '0;
            r_rsp      <= '0;
            r_crc      <= '0;
            r_crc_bad  <= 1'b0;
            r_done     <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_err_crc  <= 1'b0;
            r_clk_req  <= 1'b0;
            r_cmd      <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (cmd_valid_i) begin
                        r_frame    <= {2'b01, cmd_idx_i, cmd_arg_i, w_tx_crc, 1'b1};
                        r_bit_cnt  <= '0;
                        r_rsp_type <= rsp_type_i;
                        r_rsp      <= '0;
                        r_err_tmo  <= 1'b0;
                        r_err_crc  <= 1'b0;
                        r_clk_req  <= 1'b1;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= StTx;
                    end
                end

                StTx: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 8'd48) begin
                            // End bit has been on the line for a full bit: release.
                            r_cmd_oe  <= 1'b0;
                            r_cmd     <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_gap_cnt <= '0;
                            r_state   <= (r_rsp_type == 2'b00) ? StGap : StWaitStart;
                        end else begin
                            r_cmd     <= r_frame[47];
                            r_cmd_oe  <= 1'b1;
                            r_frame   <= {r_frame[46:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                end

                StWaitStart: begin
                    if (w_tick) begin
                        if (!sd_cmd_i) begin
                            // Start bit is response bit 0; it leaves the zero CRC unchanged.
                            r_rsp     <= {r_rsp[134:0], 1'b0};
                            r_bit_cnt <= 8'd1;
                            r_crc     <= '0;
                            r_crc_bad <= 1'b0;
                            r_state   <= StRx;
                        end else if (r_tmo_cnt == NcrMax - 16'd1) begin
                            r_err_tmo <= 1'b1;
                            r_gap_cnt <= '0;
                            r_state   <= StGap;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 16'd1;
                        end
                    end
                end

                StRx: begin
                    if (w_tick) begin
                        r_rsp     <= {r_rsp[134:0], sd_cmd_i};
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt >= w_data_lo && r_bit_cnt <= w_data_hi) begin
                            r_crc <= crc7_step(r_crc, sd_cmd_i);
                        end else if (r_bit_cnt > w_data_hi && r_bit_cnt < w_last) begin
                            // Compare the received CRC field against the running CRC, MSB first.
                            if (sd_cmd_i != r_crc[6]) begin
                                r_crc_bad <= 1'b1;
                            end
                            r_crc <= {r_crc[5:0], 1'b0};
                        end
                        if (r_bit_cnt == w_last) begin
                            r_err_crc <= ((r_rsp_type != 2'b11) && r_crc_bad) || !sd_cmd_i;
                            r_gap_cnt <= '0;
                            r_state   <= StGap;
                        end
                    end
                end

                StGap: begin
                    if (w_tick) begin
                        if (r_gap_cnt == NccGap - 16'd1) begin
                            r_clk_req <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= StDone;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 16'd1;
                        end
                    end
                end

                StDone: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o   = r_ready;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign rsp_o         = r_rsp;
    assign err_timeout_o = r_err_tmo;
    assign err_crc_o     = r_err_crc;
    assign sd_clk_req_o  = r_clk_req;
    assign sd_cmd_o      = r_cmd;
    assign sd_cmd_oe_o   = r_cmd_oe;

endmodule

// File: doc/neosd_cmd_fsm.md
# neosd_cmd_fsm

Command-line engine of the NEOSD host controller. It accepts one SD command from the register front-end, serialises it on the SD CMD line (48-bit frame with CRC7), collects the card response (none, 48-bit or 136-bit) with timeout and CRC checking, and reports completion. It sits directly downstream of the SD clock generator: it requests the SD clock from it and advances only on that generator's bit strobe.

## Interface
Parameters:
- `NCR_MAX`, 64: number of bit strobes to wait for a response start bit before declaring a timeout.
- `NCC_GAP`, 8: number of bit strobes the clock is kept running after the end of a transaction.

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rstn_i` in 1: reset, synchronous, active-low.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: high in IDLE only; the command is accepted on the cycle where `cmd_valid_i && cmd_ready_o`.
- `cmd_idx_i` in 6: command index.
- `cmd_arg_i` in 32: command argument.
- `rsp_type_i` in 2: response type: 00 none, 01 short with CRC check, 10 long (R2), 11 short without CRC check (R3).
- `rsp_o` out 136: received bits, right-aligned, first received bit in the MSB of the used field. Short responses use [47:0] and leave [135:48] zero.
- `done_o` out 1: one-cycle pulse when the transaction finishes.
- `err_timeout_o` out 1: sticky; no start bit was seen within `NCR_MAX` strobes.
- `err_crc_o` out 1: sticky; CRC mismatch or response end bit equal to 0.
- `busy_o` out 1: high in every state except IDLE.
- `clkstrb_i` in 1: bit strobe from the clock generator; one `clk_i` cycle per SD clock period.
- `sd_clk_en_i` in 1: the SD clock is running and not stalled.
- `sd_clk_req_o` out 1: request for the SD clock; drives one bit of the clock generator's request vector.
- `sd_cmd_o` out 1: CMD line output value.
- `sd_cmd_oe_o` out 1: CMD line output enable.
- `sd_cmd_i` in 1: CMD line input, already synchronised.

## Operation
- **Bit tick.** A bit tick is a cycle with `clkstrb_i && sd_clk_en_i`. All shifting, sampling and counting happens only on bit ticks; every other cycle holds state.
- **States.** IDLE, TX, WAIT_START, RX, GAP, DONE.
- **IDLE.**
  - Outputs: `sd_cmd_o`=1, `sd_cmd_oe_o`=0, `sd_clk_req_o`=0.
  - On accept: load a 48-bit frame of {0, 1, idx[5:0], arg[31:0], crc7[6:0], 1}.
  - Clear `err_timeout_o`, `err_crc_o` and `rsp_o`.
  - Set `sd_clk_req_o`=1 and go to TX.
- **CRC7.** Polynomial x^7+x^3+1, initial value 0. Computed over the first 40 frame bits, MSB first. The CRC may be computed serially during TX, provided the bit reaches the line on time.
- **TX.**
  - On each bit tick, drive the next frame bit on `sd_cmd_o` with `sd_cmd_oe_o`=1.
  - The bit is held until the next bit tick.
  - Bit counter runs 0..47.
  - On the first bit tick after bit 47 is driven:
    - set `sd_cmd_oe_o`=0 and `sd_cmd_o`=1;
    - go to GAP if `rsp_type_i` (latched at accept) is 00, otherwise go to WAIT_START.
- **WAIT_START.**
  - On each bit tick, sample `sd_cmd_i`.
  - If it is 0: store a 0 as the first response bit and go to RX.
  - Otherwise increment the strobe counter. When the counter reaches `NCR_MAX`, set `err_timeout_o` and go to GAP.
- **RX.**
  - Shift `sd_cmd_i` into `rsp_o` on each bit tick until 48 bits (short) or 136 bits (long) have been taken, start bit included.
  - Then check the response:
    - short type 01: CRC7 over bits [47:8] must equal [7:1];
    - long: CRC7 over bits [127:8] must equal [7:1];
    - type 11: no CRC check;
    - all types: bit [0] must equal 1.
  - Any failure sets `err_crc_o`. Then go to GAP.
- **GAP.**
  - Keep `sd_clk_req_o`=1 for `NCC_GAP` bit ticks.
  - Then go to DONE with `sd_clk_req_o`=0.
- **DONE.**
  - Pulse `done_o` for one cycle.
  - Return to IDLE on the next cycle.
  - Error flags and `rsp_o` stay valid until the next accept.
- **Stalls.** If `sd_clk_en_i` is low (stalled by another requester), the FSM freezes in its current state. `sd_cmd_o` and `sd_cmd_oe_o` keep their values.
- **Reset.** While `rstn_i`=0 at a `clk_i` edge, every register returns to its reset value, including mid-transaction; the line is released on the next edge. Reset values:
  - state IDLE;
  - `cmd_ready_o`=1, `busy_o`=0, `done_o`=0;
  - `err_timeout_o`=0, `err_crc_o`=0, `rsp_o`=0;
  - `sd_clk_req_o`=0, `sd_cmd_o`=1, `sd_cmd_oe_o`=0.

## Timing
- **Accept.** `busy_o`=1 and `sd_clk_req_o`=1 from the cycle after the accept.
- **First bit.** Start bit appears on `sd_cmd_o` registered in the same cycle as the first bit tick after the accept.
- **Line release.** The line is released 48 bit ticks after the first bit was driven.
- **No-response transaction.** `done_o` fires 48+1+`NCC_GAP` bit ticks after the first bit tick, plus 1 `clk_i` cycle.
- **Response sampling.** Each response bit is sampled in the cycle of its bit tick.
- **Error flags.** `err_*` are valid in the cycle `done_o` is high.
- **Overlapping request.** A `cmd_valid_i` asserted during `busy_o` is not accepted. It is accepted in IDLE, at the earliest one cycle after `done_o`.

## Test plan
1. **CMD0, no response.** `cmd_idx_i`=0, `cmd_arg_i`=0, `rsp_type_i`=00 → the line carries 0x400000000095 MSB-first, then `oe`=0. `done_o` fires after 8 gap ticks; both error flags are 0.
2. **CMD8, short response.** `cmd_idx_i`=8, `cmd_arg_i`=0x000001AA, `rsp_type_i`=01 → the frame ends in 0x87. Card model returns 0x08000001AA13 after 2 ticks → `rsp_o`[47:0]=0x08000001AA13, `err_crc_o`=0.
3. **Corrupted CRC.** Same as scenario 2, but the response carries CRC byte 0x15 → `err_crc_o`=1. With `rsp_type_i`=11 the same response gives `err_crc_o`=0.
4. **Timeout.** `rsp_type_i`=01 and the line is held at 1 → after 64 ticks in WAIT_START, `err_timeout_o`=1, then the gap, then `done_o`; `rsp_o`=0.
5. **Stall mid-frame.** `sd_clk_en_i` is forced low for 20 cycles during TX bit 10 → `sd_cmd_o` is held; the frame is still bit-exact; the bit counter has no gaps.
6. **Reset mid-frame.** `rstn_i`=0 for 1 cycle during RX → the next cycle shows IDLE, `sd_cmd_oe_o`=0, `sd_clk_req_o`=0, `cmd_ready_o`=1; a new command then completes normally.
